// File: rtl/coreapb3_iaddr_pkg.sv
// Shared definitions for the indirect-window APB3 bridge: FSM encoding and
// ERR_STICKY bit positions.
package coreapb3_iaddr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } iaddr_state_t;

    localparam int ERR_SLV_BIT = 0;
    localparam int ERR_TMO_BIT = 1;

    // Window address: base + offset, wrapping mod 2^32, optionally word aligned.
    function automatic logic [31:0] win_addr(input logic [31:0] base,
                                             input logic [31:0] off,
                                             input bit          align);
        logic [31:0] sum;
        sum = base + off;
        if (align) sum[1:0] = 2'b00;
        return sum;
    endfunction

endpackage

// File: rtl/coreapb3_iaddr_wdog.sv
// Downstream ACCESS-phase timeout counter; expires on the TIMEOUT-th
// consecutive enabled cycle. TIMEOUT = 0 removes the counter entirely.
module coreapb3_iaddr_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET)   cnt <= '0;
                else if (clr) cnt <= '0;
                else if (en)  cnt <= cnt + 1'b1;
            end

            assign expired = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/coreapb3_iaddr_bridge.sv
// Indirect-window APB3 bridge: an upstream access at window offset o becomes
// one downstream APB3 transfer at IADDR_REG + o, upstream held until it ends.
module coreapb3_iaddr_bridge
    import coreapb3_iaddr_pkg::*;
#(
    parameter int WIN_BITS   = 12,
    parameter int TIMEOUT    = 255,
    parameter bit ADDR_ALIGN = 1'b1
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [31:0]         IADDR_REG,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [WIN_BITS-1:0] PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                M_PSEL,
    output logic                M_PENABLE,
    output logic                M_PWRITE,
    output logic [31:0]         M_PADDR,
    output logic [31:0]         M_PWDATA,
    input  logic [31:0]         M_PRDATA,
    input  logic                M_PREADY,
    input  logic                M_PSLVERR,
    output logic [1:0]          ERR_STICKY,
    input  logic                ERR_CLR
);

    iaddr_state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] rdata_q;
    logic        slverr_q;
    logic        tmo_q;
    logic [1:0]  err_q;
    logic [1:0]  err_set;

    logic trigger;
    logic in_access;
    logic in_done;
    logic tmo_exp;

    assign trigger   = (state_q == IDLE) && PSEL && PENABLE;
    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    coreapb3_iaddr_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clr     (!in_access),
        .en      (in_access),
        .expired (tmo_exp)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (PSEL && PENABLE) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (M_PREADY || tmo_exp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data are frozen at the IDLE trigger so later IADDR_REG or
    // upstream changes cannot disturb the transfer in flight.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (trigger) begin
                addr_q   <= win_addr(IADDR_REG, 32'(PADDR), ADDR_ALIGN);
                write_q  <= PWRITE;
                wdata_q  <= PWRITE ? PWDATA : 32'h0;
                rdata_q  <= '0;
                slverr_q <= 1'b0;
                tmo_q    <= 1'b0;
            end else if (in_access) begin
                if (M_PREADY) begin
                    rdata_q  <= write_q ? 32'h0 : M_PRDATA;
                    slverr_q <= M_PSLVERR;
                end else if (tmo_exp) begin
                    rdata_q  <= '0;
                    tmo_q    <= 1'b1;
                end
            end
        end
    end

    // Set has priority over a same-cycle clear.
    always_comb begin
        err_set = 2'b00;
        if (in_done) begin
            err_set[ERR_SLV_BIT] = slverr_q;
            err_set[ERR_TMO_BIT] = tmo_q;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) err_q <= 2'b00;
        else        err_q <= (ERR_CLR ? 2'b00 : err_q) | err_set;
    end

    assign M_PSEL     = (state_q == SETUP) || in_access;
    assign M_PENABLE  = in_access;
    assign M_PWRITE   = write_q;
    assign M_PADDR    = addr_q;
    assign M_PWDATA   = wdata_q;

    assign PREADY     = in_done;
    assign PSLVERR    = in_done && (slverr_q || tmo_q);
    assign PRDATA     = (in_done && !write_q) ? rdata_q : 32'h0;
    assign ERR_STICKY = err_q;

endmodule

// File: tb/tb_coreapb3_iaddr_bridge.sv
// Directed bench for coreapb3_iaddr_bridge with a simple downstream slave model.
module tb_coreapb3_iaddr_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] IADDR_REG;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [31:0] M_PADDR, M_PWDATA, M_PRDATA;
    logic        M_PREADY, M_PSLVERR;
    logic [1:0]  ERR_STICKY;
    logic        ERR_CLR;

    int total = 0;
    int bad   = 0;

    // downstream slave model knobs
    int          slv_waits = 0;
    bit          slv_hang  = 1'b0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    // monitor state
    int          acc_cnt   = 0;
    int          acc_total = 0;
    int          unstable  = 0;
    logic [31:0] seen_addr  = 32'h0;
    logic [31:0] seen_wdata = 32'h0;
    logic        seen_write = 1'b0;
    int          idle_noise = 0;

    always #5 PCLK = ~PCLK;

    coreapb3_iaddr_bridge #(
        .WIN_BITS   (12),
        .TIMEOUT    (4),
        .ADDR_ALIGN (1'b1)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .IADDR_REG  (IADDR_REG),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .M_PSEL     (M_PSEL),
        .M_PENABLE  (M_PENABLE),
        .M_PWRITE   (M_PWRITE),
        .M_PADDR    (M_PADDR),
        .M_PWDATA   (M_PWDATA),
        .M_PRDATA   (M_PRDATA),
        .M_PREADY   (M_PREADY),
        .M_PSLVERR  (M_PSLVERR),
        .ERR_STICKY (ERR_STICKY),
        .ERR_CLR    (ERR_CLR)
    );

    assign M_PREADY  = M_PSEL && M_PENABLE && !slv_hang && (acc_cnt == slv_waits);
    assign M_PSLVERR = slv_err && M_PREADY;
    assign M_PRDATA  = slv_rdata;

    always @(posedge PCLK) begin
        if (M_PSEL && !M_PENABLE) begin
            seen_addr  <= M_PADDR;
            seen_wdata <= M_PWDATA;
            seen_write <= M_PWRITE;
        end
        if (M_PSEL && M_PENABLE) begin
            acc_cnt   <= acc_cnt + 1;
            acc_total <= acc_total + 1;
            if (M_PADDR != seen_addr || M_PWDATA != seen_wdata || M_PWRITE != seen_write)
                unstable <= unstable + 1;
        end else begin
            acc_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One upstream transfer; cyc counts cycles from the access phase (T0) to PREADY.
    task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                            input bit clr_in_done,
                            output logic [31:0] rd, output logic err, output int cyc);
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        step();
        PENABLE = 1'b1;
        cyc = 0;
        while (!PREADY && cyc < 20) begin
            if (PRDATA != 32'h0 || PSLVERR) idle_noise++;
            step();
            cyc++;
        end
        rd  = PRDATA;
        err = PSLVERR;
        if (clr_in_done) ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (PREADY || PRDATA != 32'h0) idle_noise++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          acc0;
        int          n;

        PRESET = 1'b1; IADDR_REG = 32'h4000_0000;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        ERR_CLR = 1'b0;
        #12;
        chk("rst_mpsel",  {30'b0, M_PSEL, M_PENABLE}, 32'h0);
        chk("rst_maddr",  M_PADDR, 32'h0);
        chk("rst_up",     {PRDATA[31:2], PREADY, PSLVERR} | PRDATA, 32'h0);
        chk("rst_sticky", {30'b0, ERR_STICKY}, 32'h0);
        step();
        PRESET = 1'b0;
        step();

        // zero-wait write
        apb_xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, rd, err, cyc);
        chk("wr_lat",    cyc, 3);
        chk("wr_maddr",  seen_addr, 32'h4000_0010);
        chk("wr_mwdata", seen_wdata, 32'hDEAD_BEEF);
        chk("wr_mwrite", {31'b0, seen_write}, 32'h1);
        chk("wr_err",    {31'b0, err}, 32'h0);
        chk("wr_prdata", rd, 32'h0);

        // read, two downstream wait states
        slv_waits = 2; slv_rdata = 32'h1234_5678;
        apb_xfer(1'b0, 12'h020, 32'hAAAA_5555, 1'b0, rd, err, cyc);
        chk("rd_lat",    cyc, 5);
        chk("rd_data",   rd, 32'h1234_5678);
        chk("rd_maddr",  seen_addr, 32'h4000_0020);
        chk("rd_mwdata", seen_wdata, 32'h0);
        chk("rd_mwrite", {31'b0, seen_write}, 32'h0);
        slv_waits = 0;

        // wrap and align
        IADDR_REG = 32'hFFFF_FFF8;
        apb_xfer(1'b0, 12'h00B, 32'h0, 1'b0, rd, err, cyc);
        chk("wrap_addr", seen_addr, 32'h0000_0000);

        // timeout
        IADDR_REG = 32'h4000_0000;
        slv_hang = 1'b1;
        acc0 = acc_total;
        apb_xfer(1'b0, 12'h030, 32'h0, 1'b0, rd, err, cyc);
        chk("to_lat",    cyc, 6);
        chk("to_acc",    acc_total - acc0, 4);
        chk("to_err",    {31'b0, err}, 32'h1);
        chk("to_data",   rd, 32'h0);
        chk("to_sticky", {30'b0, ERR_STICKY}, 32'h2);
        chk("to_mpsel",  {31'b0, M_PSEL}, 32'h0);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("to_clr",    {30'b0, ERR_STICKY}, 32'h0);
        slv_hang = 1'b0;

        // downstream slave error, clear collides with set
        slv_err = 1'b1;
        apb_xfer(1'b1, 12'h040, 32'h0BAD_F00D, 1'b1, rd, err, cyc);
        chk("se_err",    {31'b0, err}, 32'h1);
        chk("se_lat",    cyc, 3);
        chk("se_sticky", {30'b0, ERR_STICKY}, 32'h1);
        slv_err = 1'b0;
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("se_clr",    {30'b0, ERR_STICKY}, 32'h0);

        // reset in the middle of ACCESS
        IADDR_REG = 32'h5000_0000;
        slv_hang = 1'b1;
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h040; PWDATA = 32'h1111_2222;
        step();
        PENABLE = 1'b1;
        n = 0;
        while (!M_PENABLE && n < 10) begin
            step();
            n++;
        end
        chk("mr_reach", {31'b0, M_PENABLE}, 32'h1);
        IADDR_REG = 32'h6000_0000;
        step();
        chk("mr_hold",   M_PADDR, 32'h5000_0040);
        PRESET = 1'b1;
        #1;
        chk("mr_ctl",    {29'b0, M_PSEL, M_PENABLE, M_PWRITE}, 32'h0);
        chk("mr_addr",   M_PADDR, 32'h0);
        chk("mr_wdata",  M_PWDATA, 32'h0);
        chk("mr_ready",  {31'b0, PREADY}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        slv_hang = 1'b0;
        step();
        PRESET = 1'b0;
        step();
        apb_xfer(1'b1, 12'h004, 32'hCAFE_0001, 1'b0, rd, err, cyc);
        chk("pr_lat",    cyc, 3);
        chk("pr_addr",   seen_addr, 32'h6000_0004);
        chk("pr_wdata",  seen_wdata, 32'hCAFE_0001);

        chk("stable",    unstable, 0);
        chk("idle_out",  idle_noise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
